// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for the up/down counter: turns raw two-phase quadrature inputs
// (rotary encoder or panel control) into a DIR level and a one-cycle STEP
// strobe. Each channel is synchronized, then debounced; an init/run FSM keeps
// the first settled input levels from being reported as motion; a transition
// decoder produces STEP/DIR/ERR; a saturating counter tallies illegal
// (both-bits-changed) transitions.
//
// Build option:
//   QUAD_X4_EN  defined   -> STEP on every valid transition (4 per cycle)
//               undefined -> STEP only on valid transitions landing in 00
//                            (1 per cycle); DIR still follows every valid
//                            transition and ERR is unaffected.
//
// Parameters:
//   DEBOUNCE  consecutive stable edges before a filtered channel accepts a
//             new level (1..255)
//   ERR_W     width of the illegal-transition counter
//
// Ports:
//   CLK      in   system clock, rising edge
//   N_RESET  in   asynchronous active-low reset
//   A, B     in   raw quadrature phases, asynchronous to CLK
//   CLR_ERR  in   synchronous clear of ERR_CNT (wins over a same-edge error)
//   STEP     out  one-cycle pulse per accepted step
//   DIR      out  0 = forward/up, 1 = reverse/down; held between steps
//   ERR      out  one-cycle pulse on an illegal transition
//   ERR_CNT  out  saturating count of illegal transitions
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | filters settle; filtered levels load silently, no STEP/ERR
// S_RUN  | filtered {A,B} transitions decoded into STEP/DIR/ERR
// -----------------------------------------------------------------------------
module quad_step_decoder #(
   parameter int DEBOUNCE = 4,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             N_RESET,
   input  logic             A,
   input  logic             B,
   input  logic             CLR_ERR,
   output logic             STEP,
   output logic             DIR,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT
);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Filter counter terminal value: the edge on which the count would reach
   // DEBOUNCE is the edge on which the new level is accepted.
   localparam logic [7:0] FILT_TC   = 8'(DEBOUNCE - 1);
   localparam logic [7:0] STAB_LOAD = 8'(DEBOUNCE);

   // synchronizers
   logic a_s1_q, a_s1_d, a_s2_q, a_s2_d;
   logic b_s1_q, b_s1_d, b_s2_q, b_s2_d;

   // debounce filters
   logic [7:0] a_cnt_q, a_cnt_d;
   logic [7:0] b_cnt_q, b_cnt_d;
   logic       a_filt_q, a_filt_d;
   logic       b_filt_q, b_filt_d;

   // FSM, decode history and outputs
   state_t           state_q, state_d;
   logic [7:0]       stab_q, stab_d;
   logic [1:0]       prev_q, prev_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [1:0] cur_ab;
   logic [1:0] cur_pos;
   logic [1:0] prev_pos;
   logic       fwd;
   logic       rev;
   logic       dbl;
   logic       stable;

   // Gray position along the forward sequence 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] pos;
      case (ab)
         2'b00:   pos = 2'd0;
         2'b01:   pos = 2'd1;
         2'b11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   always_comb begin
      a_s1_d = A;
      a_s2_d = a_s1_q;
      b_s1_d = B;
      b_s2_d = b_s1_q;

      a_cnt_d  = '0;
      a_filt_d = a_filt_q;
      if (a_s2_q != a_filt_q) begin
         if (a_cnt_q == FILT_TC) begin
            a_filt_d = a_s2_q;
         end else begin
            a_cnt_d = a_cnt_q + 8'd1;
         end
      end

      b_cnt_d  = '0;
      b_filt_d = b_filt_q;
      if (b_s2_q != b_filt_q) begin
         if (b_cnt_q == FILT_TC) begin
            b_filt_d = b_s2_q;
         end else begin
            b_cnt_d = b_cnt_q + 8'd1;
         end
      end
   end

   // Decode compares the current filtered pair against the pair one edge
   // earlier; prev tracks the filters in both states so entering S_RUN never
   // sees a stale history.
   always_comb begin
      cur_ab   = {a_filt_q, b_filt_q};
      prev_d   = cur_ab;
      cur_pos  = gray_pos(cur_ab);
      prev_pos = gray_pos(prev_q);
      fwd      = (cur_pos == prev_pos + 2'd1);
      rev      = (prev_pos == cur_pos + 2'd1);
      dbl      = ((cur_ab ^ prev_q) == 2'b11);
      // Settled means the whole sync pipeline agrees with the filtered level,
      // so a level still in the synchronizers cannot end S_INIT early.
      stable   = (a_s1_q == a_s2_q) && (a_s2_q == a_filt_q) &&
                 (b_s1_q == b_s2_q) && (b_s2_q == b_filt_q);
   end

   always_comb begin
      state_d   = state_q;
      stab_d    = stab_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
      dir_d     = dir_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         S_INIT: begin
            if (!stable) begin
               stab_d = STAB_LOAD;
            end else if (stab_q == 8'd1) begin
               state_d = S_RUN;
            end else begin
               stab_d = stab_q - 8'd1;
            end
         end
         S_RUN: begin
            if (fwd || rev) begin
               dir_d = rev;
`ifdef QUAD_X4_EN
               step_d = 1'b1;
`else
               step_d = (cur_ab == 2'b00);
`endif
            end else if (dbl) begin
               err_d = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase

      if (CLR_ERR) begin
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         a_s1_q    <= 1'b0;
         a_s2_q    <= 1'b0;
         b_s1_q    <= 1'b0;
         b_s2_q    <= 1'b0;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         a_filt_q  <= 1'b0;
         b_filt_q  <= 1'b0;
         state_q   <= S_INIT;
         stab_q    <= STAB_LOAD;
         prev_q    <= 2'b00;
         step_q    <= 1'b0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         a_s1_q    <= a_s1_d;
         a_s2_q    <= a_s2_d;
         b_s1_q    <= b_s1_d;
         b_s2_q    <= b_s2_d;
         a_cnt_q   <= a_cnt_d;
         b_cnt_q   <= b_cnt_d;
         a_filt_q  <= a_filt_d;
         b_filt_q  <= b_filt_d;
         state_q   <= state_d;
         stab_q    <= stab_d;
         prev_q    <= prev_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign STEP    = step_q;
   assign DIR     = dir_q;
   assign ERR     = err_q;
   assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Directed bench for quad_step_decoder at DEBOUNCE=4, ERR_W=8. Inputs change
// 1 time unit after a rising edge; an input change held stable shows up on
// STEP/ERR after the 7th following rising edge. Outputs are sampled 1 unit
// after the rising edge. Expected step counts follow QUAD_X4_EN.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;

`ifdef QUAD_X4_EN
   localparam int X4 = 1;
`else
   localparam int X4 = 0;
`endif

   logic       CLK;
   logic       N_RESET;
   logic       A;
   logic       B;
   logic       CLR_ERR;
   logic       STEP;
   logic       DIR;
   logic       ERR;
   logic [7:0] ERR_CNT;

   int checks   = 0;
   int failures = 0;

   int step_total = 0;
   int err_total  = 0;
   int both_total = 0;
   int step_base;
   int err_base;

   quad_step_decoder #(
      .DEBOUNCE (4),
      .ERR_W    (8)
   ) dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .A       (A),
      .B       (B),
      .CLR_ERR (CLR_ERR),
      .STEP    (STEP),
      .DIR     (DIR),
      .ERR     (ERR),
      .ERR_CNT (ERR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (STEP === 1'b1) step_total++;
      if (ERR === 1'b1) err_total++;
      if (STEP === 1'b1 && ERR === 1'b1) both_total++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic a, input logic b);
      A = a;
      B = b;
   endtask

   logic [1:0] fwd_seq [4];
   logic [1:0] rev_seq [4];

   initial begin
      fwd_seq[0] = 2'b01; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b10; fwd_seq[3] = 2'b00;
      rev_seq[0] = 2'b10; rev_seq[1] = 2'b11; rev_seq[2] = 2'b01; rev_seq[3] = 2'b00;

      N_RESET = 1'b0;
      CLR_ERR = 1'b0;
      drive(1'b1, 1'b1);
      edges(3);
      check("rst_step", 32'(STEP), 0);
      check("rst_dir", 32'(DIR), 0);
      check("rst_err", 32'(ERR), 0);
      check("rst_errcnt", 32'(ERR_CNT), 0);

      // release with the encoder resting at 11: nothing may be reported
      N_RESET = 1'b1;
      edges(30);
      check("init11_steps", 32'(step_total), 0);
      check("init11_errs", 32'(err_total), 0);
      check("init11_errcnt", 32'(ERR_CNT), 0);

      // 11 -> 01 is reverse; DIR moving proves the FSM is running
      drive(1'b0, 1'b1);
      edges(6);
      check("run_dir_pre", 32'(DIR), 0);
      check("run_step_pre", 32'(STEP), 0);
      edges(1);
      check("run_dir", 32'(DIR), 1);
      check("run_step", 32'(STEP), 32'(X4));
      edges(3);
      drive(1'b0, 1'b0);
      edges(7);
      check("run_step00", 32'(STEP), 1);
      check("run_dir00", 32'(DIR), 1);
      edges(1);
      check("run_step00_width", 32'(STEP), 0);
      edges(2);

      // forward cycle
      step_base = step_total;
      for (int i = 0; i < 4; i++) begin
         drive(fwd_seq[i][1], fwd_seq[i][0]);
         edges(6);
         check("fwd_step_early", 32'(STEP), 0);
         edges(1);
         check("fwd_step", 32'(STEP), (X4 == 1 || i == 3) ? 1 : 0);
         check("fwd_dir", 32'(DIR), 0);
         edges(3);
      end
      check("fwd_step_count", 32'(step_total - step_base), (X4 == 1) ? 4 : 1);

      // reverse cycle
      step_base = step_total;
      for (int i = 0; i < 4; i++) begin
         drive(rev_seq[i][1], rev_seq[i][0]);
         edges(6);
         check("rev_step_early", 32'(STEP), 0);
         edges(1);
         check("rev_step", 32'(STEP), (X4 == 1 || i == 3) ? 1 : 0);
         check("rev_dir", 32'(DIR), 1);
         edges(3);
      end
      check("rev_step_count", 32'(step_total - step_base), (X4 == 1) ? 4 : 1);

      // 3-cycle glitch on A is discarded
      step_base = step_total;
      err_base  = err_total;
      drive(1'b1, 1'b0);
      edges(3);
      drive(1'b0, 1'b0);
      edges(20);
      check("glitch3_steps", 32'(step_total - step_base), 0);
      check("glitch3_errs", 32'(err_total - err_base), 0);
      check("glitch3_dir", 32'(DIR), 1);

      // 4-cycle pulse on A is accepted both ways: 00->10 (rev), 10->00 (fwd)
      step_base = step_total;
      drive(1'b1, 1'b0);
      edges(4);
      drive(1'b0, 1'b0);
      edges(20);
      check("glitch4_steps", 32'(step_total - step_base), (X4 == 1) ? 2 : 1);
      check("glitch4_dir", 32'(DIR), 0);

      // illegal 00 -> 11
      err_base  = err_total;
      step_base = step_total;
      drive(1'b1, 1'b1);
      edges(6);
      check("err_early", 32'(ERR), 0);
      edges(1);
      check("err_pulse", 32'(ERR), 1);
      check("err_nostep", 32'(STEP), 0);
      check("err_cnt1", 32'(ERR_CNT), 1);
      check("err_dir", 32'(DIR), 0);
      edges(1);
      check("err_width", 32'(ERR), 0);
      edges(2);

      // 299 more illegal toggles -> saturation
      for (int k = 1; k < 300; k++) begin
         if (k % 2 == 1) drive(1'b0, 1'b0);
         else drive(1'b1, 1'b1);
         edges(10);
      end
      check("err_total300", 32'(err_total - err_base), 300);
      check("err_cnt_sat", 32'(ERR_CNT), 255);
      check("err_steps", 32'(step_total - step_base), 0);

      // clear coincident with an error: clear wins, pulse still emitted
      drive(1'b1, 1'b1);
      edges(6);
      CLR_ERR = 1'b1;
      edges(1);
      check("clr_err_pulse", 32'(ERR), 1);
      check("clr_err_cnt", 32'(ERR_CNT), 0);
      CLR_ERR = 1'b0;
      edges(3);
      drive(1'b0, 1'b0);
      edges(7);
      check("post_clr_pulse", 32'(ERR), 1);
      check("post_clr_cnt", 32'(ERR_CNT), 1);
      check("post_clr_dir", 32'(DIR), 0);
      edges(3);

      // reset in the middle of a forward transition
      drive(1'b1, 1'b0);
      edges(10);
      check("pre_rst_dir", 32'(DIR), 1);
      drive(1'b0, 1'b0);
      edges(3);
      #2;
      N_RESET = 1'b0;
      #1;
      check("async_rst_dir", 32'(DIR), 0);
      check("async_rst_errcnt", 32'(ERR_CNT), 0);
      check("async_rst_step", 32'(STEP), 0);
      edges(2);
      N_RESET = 1'b1;
      step_base = step_total;
      edges(30);
      check("rst_drop_steps", 32'(step_total - step_base), 0);
      check("rst_drop_dir", 32'(DIR), 0);

      drive(1'b1, 1'b0);
      edges(6);
      check("rerun_dir_pre", 32'(DIR), 0);
      edges(1);
      check("rerun_dir", 32'(DIR), 1);
      edges(3);
      drive(1'b0, 1'b0);
      edges(7);
      check("rerun_step", 32'(STEP), 1);
      check("rerun_dir_fwd", 32'(DIR), 0);
      edges(3);

      check("step_err_overlap", 32'(both_total), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
